instr_queue_split: RTL and testbench

//  Parametrised instruction queue between IF and ID of the pipelined MIPS core.
//  - Buffers DEPTH fetched {pc, instr} pairs behind a valid/ready handshake.
//  - Presents the head entry split into its MIPS fields: op, rs, rt, rd, shamt, func, imm16, imm26.
//  - Decouples fetch from decode stalls; flush discards every queued instruction on a branch or jump redirect.

---
 rtl/instr_queue_split.sv | 107 ++++++++++
 tb/tb_instr_queue_split.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_split.sv
// rtl/instr_queue_split.sv - IF->ID instruction FIFO presenting the head entry split into MIPS fields.
// Optional macro IMM_EXT_EN adds the imm_ext output (extended immediate of the head entry).
module instr_queue_split #(
  parameter  int DEPTH = 4,
  parameter  int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       func,
  output logic [15:0]      imm16,
  output logic [25:0]      imm26,
  output logic             is_nop,
`ifdef IMM_EXT_EN
  output logic [31:0]      imm_ext,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      r_mem_instr [DEPTH];
  logic [PC_W-1:0]  r_mem_pc    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [31:0]      w_head_instr;

  assign w_valid   = (r_count != '0);
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = w_valid;
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = w_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage carries no reset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_pc[r_wr_ptr]    <= in_pc;
    end
  end

  assign w_head_instr = w_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
  assign out_pc       = w_valid ? r_mem_pc[r_rd_ptr] : '0;
  assign out_instr    = w_head_instr;
  assign op           = w_head_instr[31:26];
  assign rs           = w_head_instr[25:21];
  assign rt           = w_head_instr[20:16];
  assign rd           = w_head_instr[15:11];
  assign shamt        = w_head_instr[10:6];
  assign func         = w_head_instr[5:0];
  assign imm16        = w_head_instr[15:0];
  assign imm26        = w_head_instr[25:0];
  assign is_nop       = w_valid && (w_head_instr == 32'h0);

`ifdef IMM_EXT_EN
  // Logical immediates zero-extend, lui shifts up, everything else sign-extends.
  always_comb begin
    imm_ext = 32'h0;
    if (w_valid) begin
      case (w_head_instr[31:26])
        6'h0c, 6'h0d, 6'h0e: imm_ext = {16'h0, w_head_instr[15:0]};
        6'h0f:               imm_ext = {w_head_instr[15:0], 16'h0};
        default:             imm_ext = {{16{w_head_instr[15]}}, w_head_instr[15:0]};
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_instr_queue_split.sv
// tb/tb_instr_queue_split.sv - directed self-checking bench for instr_queue_split (DEPTH=4).
// Define IMM_EXT_EN to also exercise the imm_ext output.
module tb_instr_queue_split;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        is_nop;
  logic [2:0]  count;
`ifdef IMM_EXT_EN
  logic [31:0] imm_ext;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_queue_split #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imm16(imm16), .imm26(imm26), .is_nop(is_nop),
`ifdef IMM_EXT_EN
    .imm_ext(imm_ext),
`endif
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    chk({tag, "_instr"}, 64'(out_instr), 64'(instr));
    chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h8CA4_0010;
    in_pc     = 32'h0000_3000;
    out_ready = 1'b0;

    // reset held with in_valid asserted
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_op", 64'(op), 64'd0);
    chk("rst_imm26", 64'(imm26), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_is_nop", 64'(is_nop), 64'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();

    // field split of lw $a0,16($a1)
    push(32'h8CA4_0010, 32'h0000_3000);
    chk("fs_op", 64'(op), 64'h23);
    chk("fs_rs", 64'(rs), 64'd5);
    chk("fs_rt", 64'(rt), 64'd4);
    chk("fs_rd", 64'(rd), 64'd0);
    chk("fs_shamt", 64'(shamt), 64'd0);
    chk("fs_func", 64'(func), 64'h10);
    chk("fs_imm16", 64'(imm16), 64'h0010);
    chk("fs_imm26", 64'(imm26), 64'h0A4_0010);
    chk("fs_pc", 64'(out_pc), 64'h3000);
    chk("fs_count", 64'(count), 64'd1);
    chk("fs_is_nop", 64'(is_nop), 64'd0);
    pop_expect("fs_pop", 32'h8CA4_0010, 32'h0000_3000);
    chk("fs_empty_valid", 64'(out_valid), 64'd0);
    chk("fs_empty_op", 64'(op), 64'd0);

    // fill to full, then wrap
    push(32'h1111_0001, 32'h100);
    push(32'h2222_0002, 32'h104);
    push(32'h3333_0003, 32'h108);
    push(32'h4444_0004, 32'h10C);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 32'h5555_0005;
    in_pc    = 32'h110;
    tick();
    chk("full_hold_count", 64'(count), 64'd4);
    chk("full_hold_head", 64'(out_instr), 64'h1111_0001);
    out_ready = 1'b1;
    tick();
    chk("wrap_pop1_count", 64'(count), 64'd3);
    chk("wrap_pop1_head", 64'(out_instr), 64'h2222_0002);
    tick();
    chk("wrap_pushpop_count", 64'(count), 64'd3);
    out_ready = 1'b0;
    in_instr  = 32'h6666_0006;
    in_pc     = 32'h114;
    tick();
    in_valid = 1'b0;
    chk("wrap_refill_count", 64'(count), 64'd4);
    pop_expect("wrap_e3", 32'h3333_0003, 32'h108);
    pop_expect("wrap_e4", 32'h4444_0004, 32'h10C);
    pop_expect("wrap_e5", 32'h5555_0005, 32'h110);
    pop_expect("wrap_e6", 32'h6666_0006, 32'h114);
    chk("wrap_drained", 64'(count), 64'd0);

    // concurrent push and pop at count 2
    push(32'hAAAA_0001, 32'h200);
    push(32'hBBBB_0002, 32'h204);
    in_valid  = 1'b1;
    in_instr  = 32'hCCCC_0003;
    in_pc     = 32'h208;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("cc_count", 64'(count), 64'd2);
    pop_expect("cc_e2", 32'hBBBB_0002, 32'h204);
    pop_expect("cc_e3", 32'hCCCC_0003, 32'h208);

    // flush at count 3 drops the simultaneous push
    push(32'h0101_0101, 32'h300);
    push(32'h0202_0202, 32'h304);
    push(32'h0303_0303, 32'h308);
    chk("fl_pre_count", 64'(count), 64'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0404_0404;
    in_pc    = 32'h30C;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_lost", 64'(count), 64'd0);

    // nop detection
    push(32'h0, 32'h400);
    chk("nop_is_nop", 64'(is_nop), 64'd1);
    chk("nop_valid", 64'(out_valid), 64'd1);
    pop_expect("nop_pop", 32'h0, 32'h400);
    chk("nop_after", 64'(is_nop), 64'd0);

    // asynchronous reset between edges while pushing
    push(32'h7777_0007, 32'h500);
    push(32'h8888_0008, 32'h504);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h9999_0009;
    reset    = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_op", 64'(op), 64'd0);
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    chk("arst_release_count", 64'(count), 64'd0);

`ifdef IMM_EXT_EN
    chk("ie_empty", 64'(imm_ext), 64'd0);
    push(32'h3422_8001, 32'h600);
    push(32'h2422_8001, 32'h604);
    push(32'h3C02_1234, 32'h608);
    chk("ie_ori", 64'(imm_ext), 64'h0000_8001);
    pop_expect("ie_pop1", 32'h3422_8001, 32'h600);
    chk("ie_addiu", 64'(imm_ext), 64'hFFFF_8001);
    pop_expect("ie_pop2", 32'h2422_8001, 32'h604);
    chk("ie_lui", 64'(imm_ext), 64'h1234_0000);
    pop_expect("ie_pop3", 32'h3C02_1234, 32'h608);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
